cic_ctrl: RTL and testbench

Sequencer and output handshake for the 5-stage 1-bit-input CIC decimator.
- Owns the decimator's reset and `decimation_ratio`.
- Applies ratio changes safely: reset, re-run, discard settling samples.
- Converts the decimator's `d_clk`/`d_out` strobe into a valid/ready sample stream for downstream logic, with overrun accounting.
- Sits between the register/config interface and the CIC instance.

---
 rtl/cic_ctrl_pkg.sv | 22 ++
 rtl/cic_ctrl_out_buf.sv | 46 ++++
 rtl/cic_ctrl.sv | 158 +++++++++++++++
 tb/tb_cic_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared types and default constants for the CIC decimator controller.
// Defaults are also used when instantiating the CIC core itself.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESET  = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam int RATIO_W = 16;
    localparam int CNT_W   = 16;

    localparam int unsigned DEF_RATIO      = 64;
    localparam int unsigned DEF_MIN_RATIO  = 4;
    localparam int unsigned DEF_MAX_RATIO  = 16'hFFFF;
    localparam int unsigned DEF_RST_CYCLES = 4;
    localparam int unsigned DEF_DISCARD    = 6;
    localparam int unsigned DEF_DW         = 31;

endpackage

// File: rtl/cic_ctrl_out_buf.sv
// One-entry valid/ready holding register for CIC samples,
// with a saturating count of samples dropped while full.
module cic_out_buf #(
    parameter int DW    = 31,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DW-1:0]    i_data,
    input  logic             i_flush,
    input  logic             i_ready,
    output logic [DW-1:0]    o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_overrun
);

    logic [DW-1:0]    r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (r_overrun != '1) begin
                // held sample wins; the new one is lost
                r_overrun <= r_overrun + CNT_W'(1);
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/cic_ctrl.sv
// Sequencer for the 5-stage CIC decimator: owns its reset and ratio,
// restarts on ratio change and turns d_clk/d_out into a valid/ready stream.
module cic_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned DEFAULT_RATIO = DEF_RATIO,
    parameter int unsigned MIN_RATIO     = DEF_MIN_RATIO,
    parameter int unsigned MAX_RATIO     = DEF_MAX_RATIO,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned DISCARD       = DEF_DISCARD,
    parameter int          DW            = DEF_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic               cic_rst,
    output logic [RATIO_W-1:0] cic_decim,
    input  logic [DW-1:0]      cic_dout,
    input  logic               cic_dclk,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   overrun_cnt,
    output logic [1:0]         state,
    output logic               running
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_rst_cnt;
    logic [CNT_W-1:0]   r_disc_cnt;
    logic [RATIO_W-1:0] r_decim;
    logic               r_dclk_q;
    logic               r_cic_rst;
    logic               r_cfg_ready;
    logic               r_cfg_err;
    logic               r_running;
    logic               w_strobe;
    logic               w_accept;
    logic               w_in_range;
    logic               w_restart;
    logic               w_cic_rst_nxt;
    logic               w_cfg_ready_nxt;
    logic               w_running_nxt;

    assign w_accept   = cfg_valid && r_cfg_ready;
    assign w_in_range = ({1'b0, cfg_ratio} >= 17'(MIN_RATIO)) &&
                        ({1'b0, cfg_ratio} <= 17'(MAX_RATIO));
    assign w_restart  = w_accept && w_in_range;
    assign w_strobe   = cic_dclk && !r_dclk_q &&
                        (r_state == S_SETTLE || r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cic_rst   <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_running   <= 1'b0;
            r_dclk_q    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cic_rst   <= w_cic_rst_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
            r_running   <= w_running_nxt;
            r_dclk_q    <= r_cic_rst ? 1'b0 : cic_dclk;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (en) w_next = S_RESET;
            end
            S_RESET: begin
                if (!en)
                    w_next = S_IDLE;
                else if (r_rst_cnt == '0)
                    w_next = (DISCARD == 0) ? S_RUN : S_SETTLE;
            end
            S_SETTLE: begin
                if (!en)
                    w_next = S_IDLE;
                else if (w_restart)
                    w_next = S_RESET;
                else if (w_strobe && r_disc_cnt == CNT_W'(1))
                    w_next = S_RUN;
            end
            S_RUN: begin
                if (!en)
                    w_next = S_IDLE;
                else if (w_restart)
                    w_next = S_RESET;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cic_rst_nxt   = (w_next == S_IDLE) || (w_next == S_RESET);
        w_cfg_ready_nxt = (w_next != S_RESET);
        w_running_nxt   = (w_next == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_cnt  <= '0;
            r_disc_cnt <= '0;
        end else begin
            if (w_next == S_RESET && r_state != S_RESET)
                r_rst_cnt <= CNT_W'(RST_CYCLES - 1);
            else if (r_state == S_RESET && r_rst_cnt != '0)
                r_rst_cnt <= r_rst_cnt - CNT_W'(1);
            if (r_state == S_RESET && w_next == S_SETTLE)
                r_disc_cnt <= CNT_W'(DISCARD);
            else if (r_state == S_SETTLE && w_strobe)
                r_disc_cnt <= r_disc_cnt - CNT_W'(1);
        end
    end

    // ratio is latched even when en drops in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_decim   <= RATIO_W'(DEFAULT_RATIO);
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !w_in_range;
            if (w_restart) r_decim <= cfg_ratio;
        end
    end

    cic_out_buf #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_strobe && r_state == S_RUN),
        .i_data    (cic_dout),
        .i_flush   (w_cic_rst_nxt),
        .i_ready   (out_ready),
        .o_data    (out_data),
        .o_valid   (out_valid),
        .o_overrun (overrun_cnt)
    );

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign cic_rst   = r_cic_rst;
    assign cic_decim = r_decim;
    assign state     = r_state;
    assign running   = r_running;

endmodule

// File: tb/tb_cic_ctrl.sv
// Self-checking bench for cic_ctrl: scenario tasks with a
// queue of expected output samples.
module tb_cic_ctrl;

    localparam int DW = 31;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [15:0]   cfg_ratio = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          cfg_err;
    logic          cic_rst;
    logic [15:0]   cic_decim;
    logic [DW-1:0] cic_dout = '0;
    logic          cic_dclk = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   overrun_cnt;
    logic [1:0]    state;
    logic          running;

    int errors = 0;
    int checks = 0;
    int exp_ovr = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    cic_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_ratio   (cfg_ratio),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .cic_rst     (cic_rst),
        .cic_decim   (cic_decim),
        .cic_dout    (cic_dout),
        .cic_dclk    (cic_dclk),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun_cnt (overrun_cnt),
        .state       (state),
        .running     (running)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_strobe(input logic [DW-1:0] d);
        cic_dout = d;
        cic_dclk = 1'b1;
        step();
        cic_dclk = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        step(3);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (cic_rst !== 1'b1) begin errors++; $display("FAIL rst_cic_rst got=%b exp=1", cic_rst); end
        checks++; if (cic_decim !== 16'd64) begin errors++; $display("FAIL rst_decim got=%0d exp=64", cic_decim); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", out_data); end
        checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL rst_ovr got=%0d exp=0", overrun_cnt); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", running); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready got=%b exp=0", cfg_ready); end
    endtask

    // Called right after the edge that entered S_RESET.
    task automatic check_restart(input string tag);
        int n = 0;
        int bad = 0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL %s_cfg_ready got=%b exp=0", tag, cfg_ready); end
        while (state === 2'd1 && n < 20) begin
            if (cic_rst !== 1'b1) bad++;
            n++;
            step();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL %s_reset_len got=%0d exp=4", tag, n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_cic_rst_low got=%0d exp=0", tag, bad); end
        checks++; if (state !== 2'd2 || cic_rst !== 1'b0) begin
            errors++; $display("FAIL %s_settle got=%0d/%b exp=2/0", tag, state, cic_rst);
        end
        for (int i = 0; i < 6; i++) begin
            drive_strobe(DW'(32'h0F00 + i));
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_discard%0d got=%b exp=0", tag, i, out_valid); end
            step();
        end
        checks++; if (state !== 2'd3 || running !== 1'b1) begin
            errors++; $display("FAIL %s_run got=%0d/%b exp=3/1", tag, state, running);
        end
    endtask

    task automatic test_startup();
        logic [DW-1:0] e;
        rst = 1'b0;
        en  = 1'b1;
        out_ready = 1'b1;
        step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", state); end
        check_restart("start");
        sb.push_back(31'h0000ABC);
        drive_strobe(31'h0000ABC);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin
            errors++; $display("FAIL start_first got=%b/%h exp=1/%h", out_valid, out_data, e);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL start_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] e;
        logic [DW-1:0] v[2];
        v[0] = 31'h0000100;
        v[1] = 31'h0000200;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(v[i]);
            drive_strobe(v[i]);
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1 || out_data !== e) begin
                errors++; $display("FAIL stream%0d got=%b/%h exp=1/%h", i, out_valid, out_data, e);
            end
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream%0d_pulse got=%b exp=0", i, out_valid); end
        end
        checks++; if (overrun_cnt !== 16'(exp_ovr)) begin errors++; $display("FAIL stream_ovr got=%0d exp=%0d", overrun_cnt, exp_ovr); end
    endtask

    task automatic test_cfg();
        cfg_ratio = 16'd3;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err); end
        checks++; if (cic_decim !== 16'd64 || state !== 2'd3) begin
            errors++; $display("FAIL cfg_bad_kept got=%0d/%0d exp=64/3", cic_decim, state);
        end
        step();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_single got=%b exp=0", cfg_err); end
        cfg_ratio = 16'd32;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if (state !== 2'd1 || cic_rst !== 1'b1 || cic_decim !== 16'd32) begin
            errors++; $display("FAIL cfg_restart got=%0d/%b/%0d exp=1/1/32", state, cic_rst, cic_decim);
        end
        check_restart("cfg");
    endtask

    task automatic test_overrun();
        logic [DW-1:0] e;
        out_ready = 1'b0;
        sb.push_back(31'h00000A1);
        drive_strobe(31'h00000A1);
        step();
        drive_strobe(31'h00000B2);
        exp_ovr++;
        step();
        drive_strobe(31'h00000C3);
        exp_ovr++;
        checks++; if (out_valid !== 1'b1 || out_data !== 31'h00000A1) begin
            errors++; $display("FAIL ovr_hold got=%b/%h exp=1/0a1", out_valid, out_data);
        end
        checks++; if (overrun_cnt !== 16'(exp_ovr)) begin errors++; $display("FAIL ovr_cnt got=%0d exp=%0d", overrun_cnt, exp_ovr); end
        step();
        out_ready = 1'b1;
        cic_dout  = 31'h00000D4;
        cic_dclk  = 1'b1;
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin
            errors++; $display("FAIL ovr_accept got=%b/%h exp=1/%h", out_valid, out_data, e);
        end
        sb.push_back(31'h00000D4);
        step();
        cic_dclk = 1'b0;
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin
            errors++; $display("FAIL ovr_reload got=%b/%h exp=1/%h", out_valid, out_data, e);
        end
        checks++; if (overrun_cnt !== 16'(exp_ovr)) begin errors++; $display("FAIL ovr_cnt2 got=%0d exp=%0d", overrun_cnt, exp_ovr); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_en_drop();
        out_ready = 1'b0;
        sb.push_back(31'h00000E5);
        drive_strobe(31'h00000E5);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL en_held got=%b exp=1", out_valid); end
        en = 1'b0;
        step();
        sb.delete();
        checks++; if (state !== 2'd0 || cic_rst !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL en_idle got=%0d/%b/%b exp=0/1/0", state, cic_rst, out_valid);
        end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL en_cfg_ready got=%b exp=1", cfg_ready); end
        step();
        drive_strobe(31'h00000F6);
        checks++; if (out_valid !== 1'b0 || overrun_cnt !== 16'(exp_ovr)) begin
            errors++; $display("FAIL en_ignored got=%b/%0d exp=0/%0d", out_valid, overrun_cnt, exp_ovr);
        end
        step();
        out_ready = 1'b1;
    endtask

    task automatic test_rst_mid();
        en = 1'b1;
        step(5);
        checks++; if (state !== 2'd2 || cic_decim !== 16'd32) begin
            errors++; $display("FAIL mid_pre got=%0d/%0d exp=2/32", state, cic_decim);
        end
        drive_strobe(31'h0000123);
        rst = 1'b1;
        step();
        checks++; if (state !== 2'd0 || cic_decim !== 16'd64) begin
            errors++; $display("FAIL mid_rst got=%0d/%0d exp=0/64", state, cic_decim);
        end
        checks++; if (overrun_cnt !== 16'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_buf got=%0d/%b exp=0/0", overrun_cnt, out_valid);
        end
        rst = 1'b0;
        en  = 1'b0;
        step();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_left got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        step();
        test_reset();
        test_startup();
        test_stream();
        test_cfg();
        test_overrun();
        test_en_drop();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
